branch_predictor: RTL

//  Parametrised fetch-stage predictor. Replaces the fixed pc+4 next-PC guess in the 5-stage core.
//  IF sends fetch_pc. The block returns predicted_pc combinationally, from a direct-mapped BTB

---
 rtl/branch_predictor_pkg.sv | 29 ++
 rtl/branch_predictor_btb.sv | 59 +++++
 rtl/branch_predictor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-stage branch predictor.
//   MODE_*      : prediction scheme selector values
//   CTR_*       : 2-bit saturating counter encodings
//   btb_entry_t : per-entry BTB control bits (tag/target widths follow module parameters)
//   ctr_next()  : saturating counter step
package branch_predictor_pkg;

    localparam int unsigned MODE_STATIC  = 0;
    localparam int unsigned MODE_BIMODAL = 1;
    localparam int unsigned MODE_GSHARE  = 2;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic valid;
        logic cond;   // conditional branch: direction comes from the counter table
    } btb_entry_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer.
//   i_clk, i_reset       : clock, async active-high reset (clears valid bits only)
//   i_rd_idx, i_rd_tag   : combinational lookup address
//   o_rd_hit, o_rd_cond, o_rd_target : lookup result
//   i_wr_en, i_wr_idx, i_wr_tag, i_wr_target, i_wr_cond : single write port
// Reads see registered contents only, so a same-cycle write is invisible to the lookup.
module branch_predictor_btb
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned BTB_IDX = 5,
    localparam int unsigned TAG_W  = XLEN - BTB_IDX - 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [BTB_IDX-1:0] i_rd_idx,
    input  logic [TAG_W-1:0]   i_rd_tag,
    output logic               o_rd_hit,
    output logic               o_rd_cond,
    output logic [XLEN-1:0]    o_rd_target,
    input  logic               i_wr_en,
    input  logic [BTB_IDX-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [XLEN-1:0]    i_wr_target,
    input  logic               i_wr_cond
);

    localparam int unsigned ENTRIES = 1 << BTB_IDX;

    btb_entry_t       r_meta   [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];

    btb_entry_t w_rd_meta;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_meta[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_meta[i_wr_idx] <= '{valid: 1'b1, cond: i_wr_cond};
        end
    end

    // Payload needs no reset: it is never used while the entry is invalid.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]    <= i_wr_tag;
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

    assign w_rd_meta   = r_meta[i_rd_idx];
    assign o_rd_hit    = w_rd_meta.valid && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_cond   = w_rd_meta.cond;
    assign o_rd_target = r_target[i_rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC predictor: BTB + 2-bit counter table (static / bimodal / gshare).
//   i_clk, i_reset          : clock, async active-high reset
//   i_fetch_pc              : PC in IF
//   i_fetch_advance         : IF->ID accepted this cycle (drives speculative GHR shift)
//   o_predicted_pc          : combinational next-PC guess
//   o_pred_taken            : guess redirects away from fetch_pc+4
//   o_pred_ghr              : GHR snapshot used by this lookup
//   i_update_*              : resolved control-flow outcome from EX
//   o_mispredict_count      : saturating count of valid mispredict cycles
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned BTB_IDX  = 5,
    parameter int unsigned BHT_IDX  = 6,
    parameter int unsigned GHR_BITS = 6,
    parameter int unsigned MODE     = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [XLEN-1:0]     i_fetch_pc,
    input  logic                i_fetch_advance,
    output logic [XLEN-1:0]     o_predicted_pc,
    output logic                o_pred_taken,
    output logic [GHR_BITS-1:0] o_pred_ghr,
    input  logic                i_update_valid,
    input  logic [XLEN-1:0]     i_update_pc,
    input  logic                i_update_is_branch,
    input  logic                i_update_is_jump,
    input  logic                i_update_taken,
    input  logic [XLEN-1:0]     i_update_target,
    input  logic [GHR_BITS-1:0] i_update_ghr,
    input  logic                i_update_mispredict,
    output logic [31:0]         o_mispredict_count
);

    localparam int unsigned BHT_N   = 1 << BHT_IDX;
    localparam int unsigned TAG_W   = XLEN - BTB_IDX - 2;
    localparam logic        PRED_EN = (MODE != MODE_STATIC);
    localparam logic        USE_GHR = (MODE == MODE_GSHARE);

    logic [1:0]          r_bht [BHT_N];
    logic [GHR_BITS-1:0] r_ghr;
    logic [31:0]         r_mp_cnt;

    logic                w_hit;
    logic                w_cond;
    logic [XLEN-1:0]     w_btb_target;
    logic                w_pred_taken;
    logic [BHT_IDX-1:0]  w_fetch_ghr_ext;
    logic [BHT_IDX-1:0]  w_upd_ghr_ext;
    logic [BHT_IDX-1:0]  w_fetch_bht_idx;
    logic [BHT_IDX-1:0]  w_upd_bht_idx;
    logic                w_btb_we;
    logic                w_bht_we;
    logic [GHR_BITS-1:0] w_ghr_next;
    logic [31:0]         w_mp_cnt_next;
    logic                w_unused_upd_lo;

    // Instructions are word aligned; the byte offset never indexes anything.
    assign w_unused_upd_lo = ^i_update_pc[1:0];

    branch_predictor_btb #(
        .XLEN    (XLEN),
        .BTB_IDX (BTB_IDX)
    ) u_btb (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rd_idx    (i_fetch_pc[BTB_IDX+1:2]),
        .i_rd_tag    (i_fetch_pc[XLEN-1:BTB_IDX+2]),
        .o_rd_hit    (w_hit),
        .o_rd_cond   (w_cond),
        .o_rd_target (w_btb_target),
        .i_wr_en     (w_btb_we),
        .i_wr_idx    (i_update_pc[BTB_IDX+1:2]),
        .i_wr_tag    (i_update_pc[XLEN-1:BTB_IDX+2]),
        .i_wr_target (i_update_target),
        .i_wr_cond   (i_update_is_branch)
    );

    // gshare folds the (zero-extended) history into the low index bits.
    assign w_fetch_ghr_ext = USE_GHR ? BHT_IDX'(r_ghr) : '0;
    assign w_upd_ghr_ext   = USE_GHR ? BHT_IDX'(i_update_ghr) : '0;
    assign w_fetch_bht_idx = i_fetch_pc[BHT_IDX+1:2] ^ w_fetch_ghr_ext;
    assign w_upd_bht_idx   = i_update_pc[BHT_IDX+1:2] ^ w_upd_ghr_ext;

    // Jumps are always taken on a hit; branches follow the counter MSB.
    assign w_pred_taken   = PRED_EN && w_hit && (!w_cond || r_bht[w_fetch_bht_idx][1]);
    assign o_pred_taken   = w_pred_taken;
    assign o_predicted_pc = w_pred_taken ? w_btb_target : i_fetch_pc + XLEN'(4);
    assign o_pred_ghr     = r_ghr;

    // Not-taken outcomes never allocate a BTB entry.
    assign w_btb_we = PRED_EN && i_update_valid && (i_update_is_branch || i_update_is_jump)
                      && i_update_taken;
    assign w_bht_we = PRED_EN && i_update_valid && i_update_is_branch;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < BHT_N; i++) begin
                r_bht[i] <= CTR_WNT;
            end
        end else if (w_bht_we) begin
            r_bht[w_upd_bht_idx] <= ctr_next(r_bht[w_upd_bht_idx], i_update_taken);
        end
    end

    always_comb begin
        w_ghr_next = r_ghr;
        if (PRED_EN) begin
            if (i_fetch_advance && w_hit && w_cond) begin
                w_ghr_next = {r_ghr[GHR_BITS-2:0], w_pred_taken};
            end
            // Repair wins over the speculative shift of the same cycle.
            if (i_update_valid && i_update_mispredict) begin
                w_ghr_next = i_update_is_branch ? {i_update_ghr[GHR_BITS-2:0], i_update_taken}
                                                : i_update_ghr;
            end
        end
    end

    always_comb begin
        w_mp_cnt_next = r_mp_cnt;
        if (i_update_valid && i_update_mispredict && (r_mp_cnt != 32'hFFFF_FFFF)) begin
            w_mp_cnt_next = r_mp_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ghr    <= '0;
            r_mp_cnt <= '0;
        end else begin
            r_ghr    <= w_ghr_next;
            r_mp_cnt <= w_mp_cnt_next;
        end
    end

    assign o_mispredict_count = r_mp_cnt;

endmodule
